// File: rtl/div16_seq_pkg.sv
// Shared ALU package: divider width, counter width helper and the
// divider FSM state type.
package alu_pkg;

  localparam int DIV_WIDTH = 16;

  // Iteration counter must be able to hold the value WIDTH itself.
  function automatic int div_cnt_w(input int width);
    return $clog2(width) + 1;
  endfunction

  localparam int DIV_CNT_W = div_cnt_w(DIV_WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } div_state_t;

endpackage

// File: rtl/div16_seq_if.sv
// Handshake/operand bundle for the sequential divider.
//   start, A, B : request side (master drives)
//   Q, R        : quotient / remainder (slave drives)
//   busy, done  : progress status; dbz : divide-by-zero flag
interface div16_seq_if
  import alu_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) ();

  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [WIDTH-1:0] Q;
  logic [WIDTH-1:0] R;
  logic             busy;
  logic             done;
  logic             dbz;

  modport master (
    output start, A, B,
    input  Q, R, busy, done, dbz
  );

  modport slave (
    input  start, A, B,
    output Q, R, busy, done, dbz
  );

endinterface

// File: rtl/div16_seq_step.sv
// One restoring-division step (purely combinational).
//   rem      : current partial remainder, top bit dropped
//   din      : next dividend bit shifted into the remainder
//   divisor  : divisor
//   rem_next : remainder after the trial subtract
//   q_bit    : quotient bit produced by this step
// The partial remainder entering any step is below 2**(WIDTH-1) (it has
// absorbed at most WIDTH-1 dividend bits), so its MSB is always zero and
// is not needed to form the shifted value.
module div16_step
  import alu_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH-2:0] rem,
  input  logic             din,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic             q_bit
);

  logic [WIDTH-1:0] shifted;
  logic [WIDTH:0]   trial;

  always_comb begin
    shifted  = {rem, din};
    trial    = {1'b0, shifted} - {1'b0, divisor};
    q_bit    = ~trial[WIDTH];
    rem_next = q_bit ? trial[WIDTH-1:0] : shifted;
  end

endmodule

// File: rtl/div16_seq.sv
// Sequential unsigned restoring divider, one quotient bit per cycle.
//   clk   : clock, rising edge
//   reset : synchronous, active-high
//   bus   : div16_seq_if slave (start/A/B in; Q/R/busy/done/dbz out)
// Divide-by-zero skips iteration: Q = all ones, R = A, dbz = 1.
module div16_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic        clk,
  input  logic        reset,
  div16_seq_if.slave  bus
);

  localparam int CNT_W = div_cnt_w(WIDTH);

  div_state_t       state_q, state_d;
  logic [WIDTH-1:0] qsr_q, qsr_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH-1:0] step_rem;
  logic             step_q;

  div16_step #(.WIDTH(WIDTH)) u_step (
    .rem      (rem_q[WIDTH-2:0]),
    .din      (qsr_q[WIDTH-1]),
    .divisor  (dvs_q),
    .rem_next (step_rem),
    .q_bit    (step_q)
  );

  always_comb begin
    state_d = state_q;
    qsr_d   = qsr_q;
    rem_d   = rem_q;
    dvs_d   = dvs_q;
    cnt_d   = cnt_q;
    q_d     = q_q;
    r_d     = r_q;
    dbz_d   = dbz_q;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          if (bus.B != '0) begin
            qsr_d   = bus.A;
            dvs_d   = bus.B;
            rem_d   = '0;
            cnt_d   = '0;
            dbz_d   = 1'b0;
            state_d = RUN;
          end else begin
            q_d     = '1;
            r_d     = bus.A;
            dbz_d   = 1'b1;
            state_d = FIN;
          end
        end
      end
      RUN: begin
        qsr_d = {qsr_q[WIDTH-2:0], step_q};
        rem_d = step_rem;
        cnt_d = cnt_q + 1'b1;
        // Last iteration publishes this cycle's step result directly.
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          q_d     = {qsr_q[WIDTH-2:0], step_q};
          r_d     = step_rem;
          state_d = FIN;
        end
      end
      FIN: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      qsr_q   <= '0;
      rem_q   <= '0;
      dvs_q   <= '0;
      cnt_q   <= '0;
      q_q     <= '0;
      r_q     <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      qsr_q   <= qsr_d;
      rem_q   <= rem_d;
      dvs_q   <= dvs_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
      r_q     <= r_d;
      dbz_q   <= dbz_d;
    end
  end

  assign bus.Q    = q_q;
  assign bus.R    = r_q;
  assign bus.dbz  = dbz_q;
  assign bus.busy = (state_q == RUN);
  assign bus.done = (state_q == FIN);

endmodule

// File: tb/tb_div16_seq.sv
// Scoreboard bench for div16_seq: directed cases plus a random sweep with
// start held high. Expected results come from plain / and % arithmetic.
module tb_div16_seq;

  localparam int W = 16;
  localparam int SWEEP_N = 2000;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  div16_seq_if #(.WIDTH(W)) bus ();

  div16_seq #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dbz;
  } exp_t;

  exp_t exp_q[$];

  int  n_checks = 0;
  int  n_fail   = 0;
  int  cyc      = 0;
  bit  sweep_on = 1'b0;
  int  last_done = -1;
  bit  prev_done = 1'b0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_exp(input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    e.a = a;
    e.b = b;
    if (b == 0) begin
      e.q   = 16'hFFFF;
      e.r   = a;
      e.dbz = 1'b1;
    end else begin
      e.q   = a / b;
      e.r   = a % b;
      e.dbz = 1'b0;
    end
    exp_q.push_back(e);
  endtask

  // Monitor: pops one expectation per done pulse.
  always @(negedge clk) begin
    exp_t e;
    if (bus.done) begin
      check("busy_with_done", longint'(bus.busy), 0);
      check("done_consecutive", longint'(prev_done), 0);
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_done: got Q=%0d R=%0d, expected no result", bus.Q, bus.R);
      end else begin
        e = exp_q.pop_front();
        check("quotient", longint'(bus.Q), longint'(e.q));
        check("remainder", longint'(bus.R), longint'(e.r));
        check("dbz", longint'(bus.dbz), longint'(e.dbz));
        if (e.b != 0) begin
          check("invariant_aqbr", longint'(bus.Q) * longint'(e.b) + longint'(bus.R), longint'(e.a));
          check("rem_lt_divisor", longint'(bus.R < e.b), 1);
        end
      end
      if (sweep_on) begin
        if (last_done >= 0) check("done_spacing", longint'(cyc - last_done), 18);
        last_done = cyc;
      end
    end
    prev_done = bus.done;
  end

  // Caller is at a negedge with the DUT idle.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input int exp_done, input int exp_busy, input int pulse_cyc);
    int busy_n;
    int done_at;
    busy_n  = 0;
    done_at = 0;
    bus.A = a;
    bus.B = b;
    bus.start = 1'b1;
    push_exp(a, b);
    @(posedge clk);
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (n == 1) bus.start = 1'b0;
      if (pulse_cyc != 0 && n == pulse_cyc) begin
        bus.start = 1'b1;
        bus.A = 16'd9;
        bus.B = 16'd2;
      end
      if (pulse_cyc != 0 && n == pulse_cyc + 1) bus.start = 1'b0;
      if (bus.busy) busy_n++;
      if (bus.done) begin
        done_at = n;
        break;
      end
    end
    check("done_cycle", done_at, exp_done);
    check("busy_cycles", busy_n, exp_busy);
    @(negedge clk);
  endtask

  task automatic abort_op();
    bus.A = 16'd50;
    bus.B = 16'd5;
    bus.start = 1'b1;
    @(posedge clk);
    for (int n = 1; n <= 8; n++) begin
      @(negedge clk);
      if (n == 1) bus.start = 1'b0;
    end
    reset = 1'b1;
    @(negedge clk);
    check("abort_Q", longint'(bus.Q), 0);
    check("abort_R", longint'(bus.R), 0);
    check("abort_busy", longint'(bus.busy), 0);
    check("abort_done", longint'(bus.done), 0);
    check("abort_dbz", longint'(bus.dbz), 0);
    reset = 1'b0;
  endtask

  initial begin
    logic [W-1:0] a;
    logic [W-1:0] b;
    bit got;
    reset = 1'b1;
    bus.start = 1'b0;
    bus.A = '0;
    bus.B = '0;
    repeat (3) @(negedge clk);
    check("reset_Q", longint'(bus.Q), 0);
    check("reset_R", longint'(bus.R), 0);
    check("reset_busy", longint'(bus.busy), 0);
    check("reset_done", longint'(bus.done), 0);
    check("reset_dbz", longint'(bus.dbz), 0);
    reset = 1'b0;

    run_op(16'd100, 16'd7, 17, 16, 0);
    run_op(16'hFFFF, 16'd1, 17, 16, 0);
    run_op(16'hFFFF, 16'hFFFF, 17, 16, 0);
    run_op(16'd5, 16'd9, 17, 16, 0);
    run_op(16'd1234, 16'd0, 1, 0, 0);
    run_op(16'd10, 16'd3, 17, 16, 0);
    run_op(16'd50, 16'd5, 17, 16, 5);
    abort_op();
    run_op(16'd10, 16'd3, 17, 16, 0);

    sweep_on  = 1'b1;
    last_done = -1;
    for (int i = 0; i < SWEEP_N; i++) begin
      a = W'($urandom_range(0, 65535));
      b = (i % 2 == 1) ? W'($urandom_range(1, 65535)) : W'($urandom_range(1, 300));
      bus.A = a;
      bus.B = b;
      bus.start = 1'b1;
      push_exp(a, b);
      got = 1'b0;
      for (int k = 0; k < 40; k++) begin
        @(negedge clk);
        if (bus.done) begin
          got = 1'b1;
          break;
        end
      end
      if (!got) begin
        n_checks++;
        n_fail++;
        $display("FAIL sweep_timeout: got no done within 40 cycles, expected done (op %0d)", i);
      end
      if (i == SWEEP_N - 1) bus.start = 1'b0;
      @(negedge clk);
    end
    sweep_on = 1'b0;

    repeat (5) @(negedge clk);
    check("queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
